// File: rtl/am_pkg.sv
// Shared constants and elaboration-time helpers for the AM symbol encoder.
package am_pkg;

  localparam int PWM_STEPS_DEF  = 64;
  localparam int SAMPLE_W_DEF   = 8;
  localparam int DEPTH_W_DEF    = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // Right shift that maps the full-scale signed product onto +/- PWM_STEPS/2.
  function automatic int shift_amt(input int sample_w, input int depth_w, input int pwm_steps);
    return sample_w + depth_w - 1 - $clog2(pwm_steps / 2);
  endfunction

  function automatic int duty_width(input int pwm_steps);
    return $clog2(pwm_steps + 1);
  endfunction

  function automatic int prod_width(input int sample_w, input int depth_w);
    return sample_w + depth_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pushes when full and
// pops when empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are power-of-two wide, so plain increment wraps modulo DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/am_symbol_encoder.sv
// Buffers signed audio samples and, per symbol request, turns one sample into a
// depth-scaled PWM thermometer symbol through a 3-stage registered pipeline.
module am_symbol_encoder
  import am_pkg::*;
#(
  parameter int PWM_STEPS  = PWM_STEPS_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int DEPTH_W    = DEPTH_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [SAMPLE_W-1:0]                in_sample,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DEPTH_W-1:0]                 depth,
  input  logic                               sym_req,
  output logic                               sym_valid,
  output logic [PWM_STEPS-1:0]               symbol,
  output logic [$clog2(PWM_STEPS+1)-1:0]     duty,
  output logic                               busy,
  output logic                               underrun,
  input  logic                               clr_status
);

  localparam int SHIFT  = shift_amt(SAMPLE_W, DEPTH_W, PWM_STEPS);
  localparam int DUTY_W = duty_width(PWM_STEPS);
  localparam int PROD_W = prod_width(SAMPLE_W, DEPTH_W);
  localparam int HALF   = PWM_STEPS / 2;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [PWM_STEPS-1:0] SYM_MID = {{HALF{1'b1}}, {HALF{1'b0}}};

  // Input handshake: a push happens on any cycle where in_valid && in_ready;
  // in_ready depends only on the registered FIFO count (and reset), never on
  // this cycle's pop, so a full FIFO refuses a push even while it is popping.
  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                do_push, do_pop;

  logic                inflight, accept, underrun_set;

  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic [DEPTH_W-1:0]         depth_q, depth_d;
  logic                       v1_q;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic                       v2_q;
  logic [DUTY_W-1:0]          duty_q, duty_d;
  logic [PWM_STEPS-1:0]       symbol_q, symbol_d;
  logic                       sym_valid_q;
  logic                       underrun_q, underrun_d;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (do_push),
    .wdata_i (in_sample),
    .pop_i   (do_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready = ~rst & ~fifo_full;
  assign do_push  = in_valid & in_ready;

  // A request landing while any stage is occupied is dropped outright.
  assign inflight     = v1_q | v2_q | sym_valid_q;
  assign accept       = sym_req & ~inflight & ~rst;
  assign do_pop       = accept & (fifo_count != '0);
  assign underrun_set = accept & fifo_empty;

  assign busy      = ~rst & (sym_req | inflight);
  assign sym_valid = sym_valid_q;
  assign symbol    = symbol_q;
  assign duty      = duty_q;
  assign underrun  = underrun_q;

  // C0: capture the sample (or keep the last one on underrun) and the depth.
  always_comb begin
    sample_d = sample_q;
    depth_d  = depth_q;
    if (accept) begin
      depth_d = depth;
      if (do_pop) sample_d = $signed(fifo_head);
    end
  end

  // C1: signed sample times unsigned depth; depth gets a zero sign bit.
  always_comb begin
    logic signed [PROD_W-1:0] samp_ext;
    logic signed [PROD_W-1:0] dep_ext;
    samp_ext = PROD_W'(sample_q);
    dep_ext  = {{(PROD_W-DEPTH_W){1'b0}}, depth_q};
    prod_d   = samp_ext * dep_ext;
  end

  // C2: centre on half scale, floor-shift, clamp, then build the thermometer.
  always_comb begin
    logic signed [PROD_W-1:0] shifted;
    int d_int;
    shifted = prod_q >>> SHIFT;
    d_int   = HALF + int'(shifted);
    if (d_int < 0)         d_int = 0;
    if (d_int > PWM_STEPS) d_int = PWM_STEPS;
    duty_d = DUTY_W'(d_int);
    symbol_d = '0;
    for (int i = 0; i < PWM_STEPS; i++) begin
      symbol_d[i] = (i >= PWM_STEPS - d_int);
    end
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    underrun_d = underrun_q;
    if (clr_status)   underrun_d = 1'b0;
    if (underrun_set) underrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q    <= '0;
      depth_q     <= '0;
      v1_q        <= 1'b0;
      prod_q      <= '0;
      v2_q        <= 1'b0;
      duty_q      <= DUTY_W'(HALF);
      symbol_q    <= SYM_MID;
      sym_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sample_q    <= sample_d;
      depth_q     <= depth_d;
      v1_q        <= accept;
      if (v1_q) prod_q <= prod_d;
      v2_q        <= v1_q;
      if (v2_q) begin
        duty_q   <= duty_d;
        symbol_q <= symbol_d;
      end
      sym_valid_q <= v2_q;
      underrun_q  <= underrun_d;
    end
  end

endmodule
